mem_stage: RTL and testbench

Memory-access pipeline stage placed directly downstream of the execute stage and upstream of write-back. It registers the execute-stage results, performs one word load or store per instruction over a req/ack data bus, and resolves taken jumps/branches into a PC-load request. It supplies the execute stage's forwarding operand `res_mem`, and the write-back stage's result, destination and control. A timeout/alignment checker flags bus faults and never lets the pipeline hang.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Word-wide req/ack data bus between the memory stage and the data memory.
// The master holds mem_req until mem_ack; mem_rdata is valid only with mem_ack.
interface mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: registers EX results, does one word load/store, resolves jumps, feeds WB (EX->WB in 2 cycles).
// Stalls upstream while an aligned access waits for ack; a timeout or misalignment sets sticky bus_err.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] res_ex,
   input  logic [31:0] store_data_ex,
   input  logic [4:0]  rd_ex,
   input  logic        we_reg_ex,
   input  logic        read_word_ex,
   input  logic        write_word_ex,
   input  logic        link_ex,
   input  logic        set_ex,
   input  logic        condition_ex,
   input  logic        load_new_pc_ex,
   input  logic        jump_inc_ex,
   input  logic [15:0] imm_ex,
   input  logic [25:0] value_ex,
   input  logic [31:0] pc_ex,
   mem_stage_if.master bus,
   output logic        stall,
   output logic [31:0] res_mem,
   output logic        pc_load,
   output logic [31:0] new_pc,
   output logic [31:0] res_wb,
   output logic [4:0]  rd_wb,
   output logic        we_wb,
   output logic        link_wb,
   output logic        set_wb,
   output logic        condition_wb,
   output logic        bus_err
);

   // Timeout fires in the TIMEOUT-th request cycle: one IDLE cycle plus TIMEOUT-1 WAIT cycles.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 2);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   logic [31:0] s_res;
   logic [31:0] s_store_data;
   logic [4:0]  s_rd;
   logic        s_we_reg;
   logic        s_read;
   logic        s_write;
   logic        s_link;
   logic        s_set;
   logic        s_condition;
   logic        s_load_new_pc;
   logic        s_jump_inc;
   logic [15:0] s_imm;
   logic [25:0] s_value;
   logic [31:0] s_pc;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        req;
   logic        timeout;
   logic        access;
   logic        aligned;
   logic        aligned_acc;
   logic [31:0] load_val;

   assign access      = s_read | s_write;
   assign aligned     = (s_res[1:0] == 2'b00);
   assign aligned_acc = access & aligned;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_res         <= '0;
         s_store_data  <= '0;
         s_rd          <= '0;
         s_we_reg      <= 1'b0;
         s_read        <= 1'b0;
         s_write       <= 1'b0;
         s_link        <= 1'b0;
         s_set         <= 1'b0;
         s_condition   <= 1'b0;
         s_load_new_pc <= 1'b0;
         s_jump_inc    <= 1'b0;
         s_imm         <= '0;
         s_value       <= '0;
         s_pc          <= '0;
      end else if (!stall) begin
         s_res         <= res_ex;
         s_store_data  <= store_data_ex;
         s_rd          <= rd_ex;
         s_we_reg      <= we_reg_ex;
         s_read        <= read_word_ex;
         s_write       <= write_word_ex;
         s_link        <= link_ex;
         s_set         <= set_ex;
         s_condition   <= condition_ex;
         s_load_new_pc <= load_new_pc_ex;
         s_jump_inc    <= jump_inc_ex;
         s_imm         <= imm_ex;
         s_value       <= value_ex;
         s_pc          <= pc_ex;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      req      = 1'b0;
      timeout  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (aligned_acc) begin
               req = 1'b1;
               if (!bus.mem_ack) begin
                  state_nx = ST_WAIT;
                  cnt_nx   = '0;
               end
            end
         end
         ST_WAIT: begin
            req    = 1'b1;
            cnt_nx = cnt + 8'd1;
            if (bus.mem_ack) begin
               state_nx = ST_IDLE;
            end else if (cnt == LAST_WAIT) begin
               timeout  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign stall          = aligned_acc & ~(bus.mem_ack | timeout);
   assign bus.mem_req    = req;
   assign bus.mem_we     = s_write;
   assign bus.mem_addr   = s_res;
   assign bus.mem_wdata  = s_store_data;

   assign res_mem = s_link ? s_pc : s_res;
   assign pc_load = s_load_new_pc & s_condition & ~stall;
   assign new_pc  = s_jump_inc ? (s_pc + {{14{s_imm[15]}}, s_imm, 2'b00})
                               : {s_pc[31:28], s_value, 2'b00};

   // Faulted loads (misaligned or timed out) write zero rather than stale bus data.
   assign load_val = (aligned & bus.mem_ack) ? bus.mem_rdata : 32'h0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_wb       <= '0;
         rd_wb        <= '0;
         we_wb        <= 1'b0;
         link_wb      <= 1'b0;
         set_wb       <= 1'b0;
         condition_wb <= 1'b0;
      end else if (stall) begin
         we_wb   <= 1'b0;
         link_wb <= 1'b0;
         set_wb  <= 1'b0;
      end else begin
         res_wb       <= s_read ? load_val : res_mem;
         rd_wb        <= s_rd;
         we_wb        <= s_we_reg;
         link_wb      <= s_link;
         set_wb       <= s_set;
         condition_wb <= s_condition;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_err <= 1'b0;
      end else if ((access & ~aligned) | timeout) begin
         bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle sequences,
// and a random instruction stream checked against an instruction-level model.
module tb_mem_stage;
   localparam int TO = 16;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic        rdw;
      logic        wrw;
      logic        link;
      logic        set;
      logic        cond;
      logic        lnp;
      logic        jinc;
      logic [15:0] imm;
      logic [25:0] val;
   } ins_t;

   typedef struct {
      ins_t        i;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_we;
      logic        e_stall;
      logic        e_pcl;
      logic [31:0] e_resmem;
      logic [31:0] e_newpc;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_reswb;
      logic [4:0]  e_rdwb;
      logic        e_wewb;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] res_ex, store_data_ex, pc_ex;
   logic [4:0]  rd_ex;
   logic        we_reg_ex, read_word_ex, write_word_ex, link_ex, set_ex, condition_ex;
   logic        load_new_pc_ex, jump_inc_ex;
   logic [15:0] imm_ex;
   logic [25:0] value_ex;
   logic        stall, pc_load, we_wb, link_wb, set_wb, condition_wb, bus_err;
   logic [31:0] res_mem, new_pc, res_wb;
   logic [4:0]  rd_wb;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vt[9];

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .res_ex(res_ex), .store_data_ex(store_data_ex), .rd_ex(rd_ex), .we_reg_ex(we_reg_ex),
      .read_word_ex(read_word_ex), .write_word_ex(write_word_ex), .link_ex(link_ex),
      .set_ex(set_ex), .condition_ex(condition_ex), .load_new_pc_ex(load_new_pc_ex),
      .jump_inc_ex(jump_inc_ex), .imm_ex(imm_ex), .value_ex(value_ex), .pc_ex(pc_ex),
      .bus(bus),
      .stall(stall), .res_mem(res_mem), .pc_load(pc_load), .new_pc(new_pc),
      .res_wb(res_wb), .rd_wb(rd_wb), .we_wb(we_wb), .link_wb(link_wb), .set_wb(set_wb),
      .condition_wb(condition_wb), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input ins_t r);
      res_ex         = r.res;
      store_data_ex  = r.sd;
      pc_ex          = r.pc;
      rd_ex          = r.rd;
      we_reg_ex      = r.we;
      read_word_ex   = r.rdw;
      write_word_ex  = r.wrw;
      link_ex        = r.link;
      set_ex         = r.set;
      condition_ex   = r.cond;
      load_new_pc_ex = r.lnp;
      jump_inc_ex    = r.jinc;
      imm_ex         = r.imm;
      value_ex       = r.val;
   endtask

   function automatic ins_t nop_i();
      ins_t r;
      r = '0;
      return r;
   endfunction

   function automatic ins_t alu_i(input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc);
      ins_t r;
      r = '0; r.res = res; r.rd = rd; r.we = 1'b1; r.pc = pc;
      return r;
   endfunction

   function automatic ins_t load_i(input logic [31:0] a, input logic [4:0] rd);
      ins_t r;
      r = '0; r.res = a; r.rd = rd; r.we = 1'b1; r.rdw = 1'b1;
      return r;
   endfunction

   function automatic ins_t store_i(input logic [31:0] a, input logic [31:0] d);
      ins_t r;
      r = '0; r.res = a; r.sd = d; r.wrw = 1'b1;
      return r;
   endfunction

   function automatic ins_t jmp_i(input logic [31:0] pc, input logic rel, input logic [15:0] imm,
                                  input logic [25:0] val, input logic cond);
      ins_t r;
      r = '0; r.pc = pc; r.jinc = rel; r.imm = imm; r.val = val; r.cond = cond; r.lnp = 1'b1;
      return r;
   endfunction

   function automatic ins_t link_i(input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc);
      ins_t r;
      r = alu_i(res, rd, pc); r.link = 1'b1;
      return r;
   endfunction

   function automatic ins_t rand_ins();
      ins_t r;
      int   kind;
      r.res  = $urandom;
      r.sd   = $urandom;
      r.pc   = $urandom;
      r.rd   = 5'($urandom_range(0, 31));
      r.we   = 1'($urandom_range(0, 1));
      r.rdw  = 1'b0;
      r.wrw  = 1'b0;
      r.link = 1'b0;
      r.set  = 1'($urandom_range(0, 1));
      r.cond = 1'($urandom_range(0, 1));
      r.lnp  = 1'b0;
      r.jinc = 1'($urandom_range(0, 1));
      r.imm  = 16'($urandom);
      r.val  = 26'($urandom);
      kind   = $urandom_range(0, 5);
      if (kind == 2 || kind == 3) begin
         r.res = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 39) == 0) r.res = r.res | 32'($urandom_range(1, 3));
         if (kind == 2) begin r.rdw = 1'b1; r.we = 1'b1; end
         else begin r.wrw = 1'b1; r.we = ($urandom_range(0, 7) == 0); end
      end else if (kind == 4) begin
         r.lnp = 1'b1;
      end else if (kind == 5) begin
         r.link = 1'b1;
      end
      return r;
   endfunction

   // Instruction-level reference: the instruction occupying the stage, how many cycles it
   // has been requesting, and what write-back should show.
   ins_t        cur, nxt;
   logic [31:0] m_reswb;
   logic [4:0]  m_rd;
   logic        m_we, m_link, m_set, m_cond, m_err;
   int          req_n;
   logic        prev_stall;

   initial begin : main
      logic        acc, al, rq, to, e_stall, ack, deaf, done;
      logic [31:0] rdata, e_resmem, e_npc;
      int          off, reqc, stc;

      // {instruction, ack, rdata | comb: req we stall pc_load res_mem new_pc addr wdata | WB: res rd we}
      vt[0] = '{alu_i(32'd5, 5'd3, 32'h10), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};
      vt[1] = '{alu_i(32'd7, 5'd4, 32'h14), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'h0, 32'd5, 32'h0, 32'd5, 5'd3, 1'b1};
      vt[2] = '{store_i(32'h20, 32'h12345678), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'h0, 32'd7, 32'h0, 32'd7, 5'd4, 1'b1};
      vt[3] = '{jmp_i(32'h40, 1'b1, 16'hFFFE, 26'h0, 1'b1), 1'b1, 32'hDEAD0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h20, 32'h12345678, 32'h20, 5'd0, 1'b0};
      vt[4] = '{jmp_i(32'hA0000000, 1'b0, 16'h0, 26'h10, 1'b1), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h38, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};
      vt[5] = '{jmp_i(32'h40, 1'b1, 16'hFFFE, 26'h0, 1'b0), 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hA0000040, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};
      vt[6] = '{link_i(32'h999, 5'd31, 32'h200), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h38, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};
      vt[7] = '{nop_i(), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h999, 32'h0, 32'h200, 5'd31, 1'b1};
      vt[8] = '{nop_i(), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};

      reset_n = 1'b1;
      drive(nop_i());
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      #1 reset_n = 1'b0;
      #2;
      chk_b("reset mem_req", bus.mem_req, 1'b0);
      chk_b("reset stall", stall, 1'b0);
      chk_b("reset pc_load", pc_load, 1'b0);
      chk_w("reset res_mem", res_mem, 32'h0);
      chk_w("reset new_pc", new_pc, 32'h0);
      chk_w("reset res_wb", res_wb, 32'h0);
      chk_b("reset we_wb", we_wb, 1'b0);
      chk_b("reset bus_err", bus_err, 1'b0);
      @(negedge clk) reset_n = 1'b1;
      tick();

      for (int k = 0; k < 9; k++) begin
         drive(vt[k].i);
         bus.mem_ack   = vt[k].ack;
         bus.mem_rdata = vt[k].rdata;
         #1;
         chk_b($sformatf("vec%0d mem_req", k), bus.mem_req, vt[k].e_req);
         chk_b($sformatf("vec%0d mem_we", k), bus.mem_we, vt[k].e_we);
         chk_b($sformatf("vec%0d stall", k), stall, vt[k].e_stall);
         chk_b($sformatf("vec%0d pc_load", k), pc_load, vt[k].e_pcl);
         chk_w($sformatf("vec%0d res_mem", k), res_mem, vt[k].e_resmem);
         chk_w($sformatf("vec%0d new_pc", k), new_pc, vt[k].e_newpc);
         chk_w($sformatf("vec%0d mem_addr", k), bus.mem_addr, vt[k].e_addr);
         chk_w($sformatf("vec%0d mem_wdata", k), bus.mem_wdata, vt[k].e_wdata);
         tick();
         chk_w($sformatf("vec%0d res_wb", k), res_wb, vt[k].e_reswb);
         chk_w($sformatf("vec%0d rd_wb", k), 32'(rd_wb), 32'(vt[k].e_rdwb));
         chk_b($sformatf("vec%0d we_wb", k), we_wb, vt[k].e_wewb);
      end
      bus.mem_ack = 1'b0;
      chk_b("no fault after table", bus_err, 1'b0);

      // Load at 0x100 acked in its fourth request cycle.
      drive(alu_i(32'h11, 5'd9, 32'h300));
      tick();
      drive(load_i(32'h100, 5'd7));
      tick();
      reqc = 0; stc = 0;
      for (int c = 0; c < 6; c++) begin
         bus.mem_ack   = (c == 3);
         bus.mem_rdata = (c == 3) ? 32'hCAFEBABE : 32'h0BAD0BAD;
         #1;
         if (bus.mem_req) reqc++;
         if (stall) stc++;
         if (!stall) drive(nop_i());
         tick();
         if (c < 3) chk_b($sformatf("load bubble%0d we_wb", c), we_wb, 1'b0);
         if (c == 0) begin
            chk_w("bubble holds res_wb", res_wb, 32'h11);
            chk_w("bubble holds rd_wb", 32'(rd_wb), 32'd9);
         end
         if (c == 3) begin
            chk_w("load res_wb", res_wb, 32'hCAFEBABE);
            chk_w("load rd_wb", 32'(rd_wb), 32'd7);
            chk_b("load we_wb", we_wb, 1'b1);
         end
      end
      bus.mem_ack = 1'b0;
      chk_w("load req cycles", 32'(reqc), 32'd4);
      chk_w("load stall cycles", 32'(stc), 32'd3);
      chk_b("no fault after load", bus_err, 1'b0);

      // Load that is never acked must time out.
      drive(load_i(32'h104, 5'd8));
      tick();
      reqc = 0; stc = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (bus.mem_req) reqc++;
         if (stall) stc++;
         done = !stall;
         if (done) drive(nop_i());
         tick();
         if (!done && c == 0) chk_b("bus_err quiet while waiting", bus_err, 1'b0);
      end
      chk_b("timeout released", done, 1'b1);
      chk_w("timeout stall cycles", 32'(stc), 32'(TO - 1));
      chk_w("timeout req cycles", 32'(reqc), 32'(TO));
      chk_b("timeout bus_err", bus_err, 1'b1);
      chk_w("timeout res_wb", res_wb, 32'h0);
      chk_b("timeout we_wb", we_wb, 1'b1);

      // Reset in the middle of a WAIT.
      drive(load_i(32'h108, 5'd2));
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         tick();
      end
      #1;
      chk_b("mid-wait mem_req", bus.mem_req, 1'b1);
      chk_b("mid-wait stall", stall, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk_b("async reset mem_req", bus.mem_req, 1'b0);
      chk_b("async reset stall", stall, 1'b0);
      chk_b("async reset bus_err", bus_err, 1'b0);
      chk_w("async reset res_wb", res_wb, 32'h0);
      chk_w("async reset res_mem", res_mem, 32'h0);
      chk_w("async reset mem_addr", bus.mem_addr, 32'h0);
      drive(nop_i());
      @(negedge clk) reset_n = 1'b1;
      tick();

      drive(load_i(32'h300, 5'd5));
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h55AA0011;
      #1;
      chk_b("post-reset load mem_req", bus.mem_req, 1'b1);
      chk_b("post-reset load stall", stall, 1'b0);
      drive(nop_i());
      tick();
      bus.mem_ack = 1'b0;
      chk_w("post-reset load res_wb", res_wb, 32'h55AA0011);
      chk_b("post-reset load we_wb", we_wb, 1'b1);
      chk_b("post-reset bus_err", bus_err, 1'b0);

      drive(load_i(32'h102, 5'd6));
      tick();
      #1;
      chk_b("misaligned mem_req", bus.mem_req, 1'b0);
      chk_b("misaligned stall", stall, 1'b0);
      drive(nop_i());
      tick();
      chk_b("misaligned bus_err", bus_err, 1'b1);
      chk_w("misaligned res_wb", res_wb, 32'h0);

      // Random instruction stream against the model.
      reset_n = 1'b0;
      drive(nop_i());
      #3;
      @(negedge clk) reset_n = 1'b1;
      tick();
      cur = nop_i(); nxt = nop_i();
      m_reswb = '0; m_rd = '0; m_we = 0; m_link = 0; m_set = 0; m_cond = 0; m_err = 0;
      req_n = 0; prev_stall = 1'b0; deaf = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!prev_stall) begin
            nxt  = rand_ins();
            deaf = ($urandom_range(0, 9) == 0);
         end
         ack   = deaf ? 1'b0 : ($urandom_range(0, 2) == 0);
         rdata = $urandom;
         drive(nxt);
         bus.mem_ack   = ack;
         bus.mem_rdata = rdata;
         #1;
         acc      = cur.rdw | cur.wrw;
         al       = (cur.res % 4) == 0;
         rq       = acc && al;
         to       = rq && !ack && (req_n + 1 == TO);
         e_stall  = rq && !ack && !to;
         e_resmem = cur.link ? cur.pc : cur.res;
         off      = $signed(cur.imm);
         if (cur.jinc) e_npc = cur.pc + 32'(off * 4);
         else          e_npc = (cur.pc & 32'hF000_0000) + 32'(cur.val) * 32'd4;
         chk_b("rnd stall", stall, e_stall);
         chk_b("rnd mem_req", bus.mem_req, rq);
         chk_b("rnd mem_we", bus.mem_we, cur.wrw);
         chk_w("rnd mem_addr", bus.mem_addr, cur.res);
         chk_w("rnd mem_wdata", bus.mem_wdata, cur.sd);
         chk_w("rnd res_mem", res_mem, e_resmem);
         chk_w("rnd new_pc", new_pc, e_npc);
         chk_b("rnd pc_load", pc_load, cur.lnp && cur.cond && !e_stall);
         if ((acc && !al) || to) m_err = 1'b1;
         if (e_stall) begin
            m_we = 0; m_link = 0; m_set = 0;
            req_n++;
         end else begin
            m_reswb = cur.rdw ? ((al && ack) ? rdata : 32'h0) : e_resmem;
            m_rd    = cur.rd;
            m_we    = cur.we;
            m_link  = cur.link;
            m_set   = cur.set;
            m_cond  = cur.cond;
            cur     = nxt;
            req_n   = 0;
         end
         prev_stall = e_stall;
         tick();
         chk_w("rnd res_wb", res_wb, m_reswb);
         chk_w("rnd rd_wb", 32'(rd_wb), 32'(m_rd));
         chk_b("rnd we_wb", we_wb, m_we);
         chk_b("rnd link_wb", link_wb, m_link);
         chk_b("rnd set_wb", set_wb, m_set);
         chk_b("rnd condition_wb", condition_wb, m_cond);
         chk_b("rnd bus_err", bus_err, m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
